// File: rtl/fp16_add_arbiter_pkg.sv
// Shared types for the fp16 adder arbiter: response/tracker entries.
// Field widths cover the largest supported NREQ and TAGW.
package fp16_arb_pkg;

    localparam int FP16_W      = 16;
    localparam int ADD_LAT_DEF = 3;
    localparam int ID_W_MAX    = 3;
    localparam int TAG_W_MAX   = 8;

    typedef struct packed {
        logic [ID_W_MAX-1:0]  id;
        logic [TAG_W_MAX-1:0] tag;
        logic [FP16_W-1:0]    sum;
    } rsp_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [ID_W_MAX-1:0]  id;
        logic [TAG_W_MAX-1:0] tag;
    } trk_entry_t;

endpackage

// File: rtl/fp16_add_arbiter_if.sv
// Request, adder-operand and response bundle for fp16_add_arbiter.
// master = requesters/adder/consumer side, slave = the arbiter.
interface fp16_add_arbiter_if
    import fp16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [FP16_W*NREQ-1:0] req_a;
    logic [FP16_W*NREQ-1:0] req_b;
    logic [TAGW*NREQ-1:0]   req_tag;
    logic [FP16_W-1:0]      add_a;
    logic [FP16_W-1:0]      add_b;
    logic [FP16_W-1:0]      add_sum;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [TAGW-1:0]        rsp_tag;
    logic [FP16_W-1:0]      rsp_sum;

    modport master (
        output req_valid, req_a, req_b, req_tag, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_tag, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, add_sum, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_tag, rsp_sum
    );

endinterface

// File: rtl/fp16_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 enable,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    int   idx;
    logic hit;

    always_comb begin
        gnt = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (enable && !hit && req[idx]) begin
                gnt[idx] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Shares one fixed-latency fp16 adder among NREQ requesters; results
// return in issue order through a credit-protected response FIFO.
module fp16_add_arbiter
    import fp16_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int TAGW    = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk10,
    input  logic               reset10,
    fp16_add_arbiter_if.slave  bus,
    output logic               busy
);

    localparam int IDW  = $clog2(NREQ);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int IW   = CW + 1;
    localparam int NSTG = ADD_LAT + 1;

    trk_entry_t       trk [NSTG];
    trk_entry_t       trk_in;
    rsp_entry_t       mem [DEPTH];
    rsp_entry_t       head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;
    logic [IW-1:0]    inflight;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   sel;
    logic [NREQ-1:0]  gnt;
    logic             permit;
    logic             accept;
    logic             push;
    logic             pop;
    logic             unused_head;

    always_comb begin
        inflight = '0;
        for (int s = 0; s < NSTG; s++) begin
            inflight = inflight + IW'(trk[s].valid);
        end
    end

    // A pop in this cycle earns no credit until the next one.
    assign permit = ({1'b0, fifo_count} + inflight) < IW'(DEPTH);

    rr_arbiter #(.N(NREQ)) u_arb (
        .req    (bus.req_valid),
        .enable (permit),
        .ptr    (ptr),
        .gnt    (gnt)
    );

    assign bus.req_ready = gnt;
    assign accept        = |gnt;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel = sel | IDW'(i);
        end
    end

    always_comb begin
        trk_in       = '0;
        trk_in.valid = accept;
        trk_in.id    = ID_W_MAX'(sel);
        trk_in.tag   = TAG_W_MAX'(bus.req_tag[int'(sel)*TAGW +: TAGW]);
    end

    always_ff @(posedge clk10 or posedge reset10) begin
        if (reset10) begin
            ptr       <= IDW'(NREQ - 1);
            bus.add_a <= '0;
            bus.add_b <= '0;
            for (int s = 0; s < NSTG; s++) trk[s] <= '0;
        end else begin
            bus.add_a <= accept ? bus.req_a[int'(sel)*FP16_W +: FP16_W] : '0;
            bus.add_b <= accept ? bus.req_b[int'(sel)*FP16_W +: FP16_W] : '0;
            trk[0]    <= trk_in;
            for (int s = 1; s < NSTG; s++) trk[s] <= trk[s-1];
            if (accept) ptr <= sel;
        end
    end

    assign push          = trk[ADD_LAT].valid;
    assign bus.rsp_valid = (fifo_count != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk10) begin
        if (push) mem[wr_ptr] <= {trk[ADD_LAT].id, trk[ADD_LAT].tag, bus.add_sum};
    end

    always_ff @(posedge clk10 or posedge reset10) begin
        if (reset10) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head fields read as zero while the FIFO is empty.
    assign bus.rsp_id  = bus.rsp_valid ? IDW'(head.id)   : '0;
    assign bus.rsp_tag = bus.rsp_valid ? TAGW'(head.tag) : '0;
    assign bus.rsp_sum = bus.rsp_valid ? head.sum        : '0;
    assign unused_head = ^{head.id, head.tag};

    assign busy = (inflight != '0) | (fifo_count != '0);

    a_no_overflow: assert property (
        @(posedge clk10) disable iff (reset10)
        push |-> (fifo_count != CW'(DEPTH))
    );

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: real-valued fp16 adder stub plus a
// queue-based model of issue, latency, credit and response order.
module tb_fp16_add_arbiter;

    localparam int NREQ    = 4;
    localparam int ADD_LAT = 3;
    localparam int TAGW    = 4;
    localparam int DEPTH   = 8;

    logic clk10   = 1'b0;
    logic reset10 = 1'b1;
    logic busy;

    fp16_add_arbiter_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

    fp16_add_arbiter #(
        .NREQ(NREQ), .ADD_LAT(ADD_LAT), .TAGW(TAGW), .DEPTH(DEPTH)
    ) dut (
        .clk10   (clk10),
        .reset10 (reset10),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk10 = ~clk10;

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  p;
        r = (h[14:10] == 5'd0) ? real'(h[9:0]) : real'(1024 + h[9:0]);
        p = (h[14:10] == 5'd0) ? -24 : int'(h[14:10]) - 25;
        while (p > 0) begin r = r * 2.0; p--; end
        while (p < 0) begin r = r / 2.0; p++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  m;
        int   e;
        int   f;
        s = (r < 0.0);
        m = s ? -r : r;
        if (m == 0.0) return 16'h0000;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > -14) begin m = m * 2.0; e--; end
        if (m < 1.0) begin
            f = $rtoi(m * 1024.0 + 0.5);
            return {s, 15'(f)};
        end
        f = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (f == 1024) begin f = 0; e++; end
        if (e + 15 >= 31) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(f)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] rnd_fp();
        return {1'($urandom), 5'($urandom_range(1, 29)), 10'($urandom)};
    endfunction

    logic [15:0] add_pipe [ADD_LAT];

    always_ff @(posedge clk10 or posedge reset10) begin
        if (reset10) begin
            for (int k = 0; k < ADD_LAT; k++) add_pipe[k] <= '0;
        end else begin
            add_pipe[0] <= fadd(bus.add_a, bus.add_b);
            for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
        end
    end

    assign bus.add_sum = add_pipe[ADD_LAT-1];

    typedef struct {
        int          id;
        int          tag;
        logic [15:0] sum;
        int          stage;
    } op_t;

    op_t mpipe[$];
    op_t mfifo[$];
    int  mptr;

    logic [15:0] ra [NREQ];
    logic [15:0] rb [NREQ];
    logic [3:0]  rt [NREQ];

    logic [3:0]  o_ready;
    logic        o_rv;
    logic [1:0]  o_id;
    logic [3:0]  o_tag;
    logic [15:0] o_sum;
    logic        o_busy;
    logic [27:0] obs;
    logic [27:0] expv;

    int n_vec = 0;
    int n_bad = 0;

    task automatic model_clear();
        mpipe.delete();
        mfifo.delete();
        mptr = NREQ - 1;
    endtask

    // Drives one cycle, captures observed and model-expected state.
    task automatic step(input logic [3:0] rv, input logic rdy);
        logic [3:0] g;
        op_t        h;
        op_t        o;
        op_t        np[$];
        bus.req_valid = rv;
        bus.rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[16*i +: 16] = ra[i];
            bus.req_b[16*i +: 16] = rb[i];
            bus.req_tag[4*i +: 4] = rt[i];
        end
        #1;
        o_ready = bus.req_ready;
        o_rv    = bus.rsp_valid;
        o_id    = bus.rsp_id;
        o_tag   = bus.rsp_tag;
        o_sum   = bus.rsp_sum;
        o_busy  = busy;
        g = '0;
        if (mfifo.size() + mpipe.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (mptr + k) % NREQ;
                if (g == '0 && rv[idx]) g[idx] = 1'b1;
            end
        end
        h = '{id: 0, tag: 0, sum: 16'h0, stage: 0};
        if (mfifo.size() != 0) h = mfifo[0];
        expv = {g, mfifo.size() != 0, 2'(h.id), 4'(h.tag), h.sum,
                (mfifo.size() + mpipe.size()) != 0};
        obs  = {o_ready, o_rv, o_id, o_tag, o_sum, o_busy};
        @(posedge clk10);
        if (rdy && mfifo.size() != 0) void'(mfifo.pop_front());
        np = {};
        foreach (mpipe[j]) begin
            o = mpipe[j];
            if (o.stage == ADD_LAT) mfifo.push_back(o);
            else begin o.stage++; np.push_back(o); end
        end
        mpipe = np;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                o.id = i; o.tag = int'(rt[i]);
                o.sum = fadd(ra[i], rb[i]); o.stage = 0;
                mpipe.push_back(o);
                mptr = i;
            end
        end
        @(negedge clk10);
    endtask

    task automatic do_reset();
        reset10 = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk10);
        @(negedge clk10);
        reset10 = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset10 = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk10);
        @(negedge clk10);
        #1;
        n_vec++; if (bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL reset req_ready got %h want 0", bus.req_ready); end
        n_vec++; if (bus.add_a !== 16'h0) begin n_bad++; $display("FAIL reset add_a got %h want 0", bus.add_a); end
        n_vec++; if (bus.add_b !== 16'h0) begin n_bad++; $display("FAIL reset add_b got %h want 0", bus.add_b); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'h0) begin n_bad++; $display("FAIL reset rsp_id got %h want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_tag !== 4'h0) begin n_bad++; $display("FAIL reset rsp_tag got %h want 0", bus.rsp_tag); end
        n_vec++; if (bus.rsp_sum !== 16'h0) begin n_bad++; $display("FAIL reset rsp_sum got %h want 0", bus.rsp_sum); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", busy); end
        reset10 = 1'b0;
        model_clear();
        @(negedge clk10);
    endtask

    task automatic test_single();
        int first;
        logic [21:0] rsp;
        do_reset();
        ra[2] = 16'h3C00; rb[2] = 16'h4000; rt[2] = 4'd5;
        step(4'b0100, 1'b1);
        n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL single c0 got %h want %h", obs, expv); end
        n_vec++; if (o_ready !== 4'b0100) begin n_bad++; $display("FAIL single grant got %b want 0100", o_ready); end
        first = -1;
        rsp = '0;
        for (int j = 1; j <= 7; j++) begin
            step(4'b0000, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL single c%0d got %h want %h", j, obs, expv); end
            if (o_rv && first < 0) begin first = j; rsp = {o_id, o_tag, o_sum}; end
        end
        n_vec++; if (first !== 5) begin n_bad++; $display("FAIL single latency got step %0d want 5", first); end
        n_vec++; if (rsp !== {2'd2, 4'd5, 16'h4200}) begin n_bad++; $display("FAIL single rsp got %h want %h", rsp, {2'd2, 4'd5, 16'h4200}); end
    endtask

    task automatic test_all_four();
        logic [3:0] pend;
        logic [3:0] gq[$];
        int rid[$];
        int rcyc[$];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin ra[i] = 16'h3E00; rb[i] = 16'h3E00; rt[i] = 4'(i); end
        pend = 4'hF;
        for (int j = 0; j < 12; j++) begin
            step(pend, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL all4 c%0d got %h want %h", j, obs, expv); end
            if (o_ready != 0) begin gq.push_back(o_ready); pend = pend & ~o_ready; end
            if (o_rv) begin
                rid.push_back(int'(o_id)); rcyc.push_back(j);
                n_vec++; if (o_sum !== 16'h4200) begin n_bad++; $display("FAIL all4 sum got %h want 4200", o_sum); end
            end
        end
        n_vec++; if (gq.size() != 4 || rid.size() != 4) begin
            n_bad++; $display("FAIL all4 counts got %0d/%0d want 4/4", gq.size(), rid.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (gq[k] !== 4'(1 << k)) begin n_bad++; $display("FAIL all4 grant%0d got %b want %b", k, gq[k], 4'(1 << k)); end
                n_vec++; if (rid[k] != k) begin n_bad++; $display("FAIL all4 rsp_id%0d got %0d want %0d", k, rid[k], k); end
            end
            n_vec++; if (rcyc[3] - rcyc[0] != 3) begin n_bad++; $display("FAIL all4 spread got %0d want 3", rcyc[3] - rcyc[0]); end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin ra[i] = rnd_fp(); rb[i] = rnd_fp(); rt[i] = 4'($urandom); end
        for (int j = 0; j < 8; j++) begin
            step(4'b0101, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL alt c%0d got %h want %h", j, obs, expv); end
            n_vec++; if (o_ready !== ((j % 2) ? 4'b0100 : 4'b0001)) begin
                n_bad++; $display("FAIL alt grant c%0d got %b want %b", j, o_ready, (j % 2) ? 4'b0100 : 4'b0001);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int acc2;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin ra[i] = rnd_fp(); rb[i] = rnd_fp(); rt[i] = 4'($urandom); end
        acc = 0;
        for (int j = 0; j < 14; j++) begin
            step(4'hF, 1'b0);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL bp hold c%0d got %h want %h", j, obs, expv); end
            if (o_ready != 0) acc++;
        end
        n_vec++; if (acc != DEPTH) begin n_bad++; $display("FAIL bp accepts got %0d want %0d", acc, DEPTH); end
        n_vec++; if (o_ready !== 4'h0) begin n_bad++; $display("FAIL bp stalled grant got %b want 0", o_ready); end
        acc2 = 0;
        for (int j = 0; j < 20; j++) begin
            ra[j % NREQ] = rnd_fp();
            step(4'hF, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL bp drain c%0d got %h want %h", j, obs, expv); end
            if (o_ready != 0) acc2++;
        end
        n_vec++; if (acc2 == 0) begin n_bad++; $display("FAIL bp resume got 0 accepts want >0"); end
        for (int j = 0; j < 12; j++) begin
            step(4'h0, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL bp idle c%0d got %h want %h", j, obs, expv); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ra[1] = rnd_fp(); rb[1] = rnd_fp(); rt[1] = 4'd9;
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        reset10 = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid busy got %b want 0", busy); end
        n_vec++; if (bus.add_a !== 16'h0) begin n_bad++; $display("FAIL rstmid add_a got %h want 0", bus.add_a); end
        model_clear();
        @(negedge clk10);
        reset10 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step(4'b0000, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL rstmid c%0d got %h want %h", j, obs, expv); end
            n_vec++; if (o_rv !== 1'b0) begin n_bad++; $display("FAIL rstmid rsp_valid got %b want 0", o_rv); end
        end
        step(4'hF, 1'b1);
        n_vec++; if (o_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid next grant got %b want 0001", o_ready); end
        for (int j = 0; j < 8; j++) step(4'h0, 1'b1);
    endtask

    task automatic test_push_pop_full();
        int tags[$];
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            ra[0] = rnd_fp(); rb[0] = rnd_fp(); rt[0] = 4'(k);
            step(4'b0001, 1'b0);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL ppf fill c%0d got %h want %h", k, obs, expv); end
        end
        for (int k = 0; k < ADD_LAT; k++) begin
            step(4'b0000, 1'b0);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL ppf wait c%0d got %h want %h", k, obs, expv); end
        end
        step(4'b0000, 1'b1);
        n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL ppf pushpop got %h want %h", obs, expv); end
        n_vec++; if (o_tag !== 4'd0 || o_rv !== 1'b1) begin n_bad++; $display("FAIL ppf head got v%b t%0d want v1 t0", o_rv, o_tag); end
        for (int j = 0; j < 12; j++) begin
            step(4'b0000, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL ppf drain c%0d got %h want %h", j, obs, expv); end
            if (o_rv) tags.push_back(int'(o_tag));
        end
        n_vec++; if (tags.size() != DEPTH - 1) begin
            n_bad++; $display("FAIL ppf drained got %0d want %0d", tags.size(), DEPTH - 1);
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                n_vec++; if (tags[k] != k + 1) begin n_bad++; $display("FAIL ppf order%0d got %0d want %0d", k, tags[k], k + 1); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < NREQ; i++) begin ra[i] = rnd_fp(); rb[i] = rnd_fp(); rt[i] = 4'($urandom); end
            step(4'($urandom), $urandom_range(0, 3) != 0);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL rand c%0d got %h want %h", j, obs, expv); end
        end
        for (int j = 0; j < 16; j++) begin
            step(4'h0, 1'b1);
            n_vec++; if (obs !== expv) begin n_bad++; $display("FAIL rand drain c%0d got %h want %h", j, obs, expv); end
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; rt[i] = '0; end
        model_clear();
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_push_pop_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp16_add_arbiter.md
# fp16_add_arbiter

Round-robin scheduler that shares one pipelined fp16 adder among NREQ requesters. It grants at most one operand pair per cycle and drives the adder's operand inputs. It tracks each in-flight operation with a latency-matched tag pipeline and returns results through a credit-protected response FIFO. It sits between the requesting engines and the fixed-latency, non-stallable adder instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADD_LAT, 3, adder register stages: register edges from operand-in to sum-out
- TAGW, 4, requester-supplied tag width
- DEPTH, 8, response FIFO entries; power of two, at least ADD_LAT+1
- clk10  in  1  clock
- reset10  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  grant; one-hot or zero
- req_a  in  16*NREQ  fp16 operand A, requester i at [16i+15:16i]
- req_b  in  16*NREQ  fp16 operand B, same packing
- req_tag  in  TAGW*NREQ  tag, same packing
- add_a  out  16  registered operand A to adder
- add_b  out  16  registered operand B to adder
- add_sum  in  16  adder result
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  $clog2(NREQ)  originating requester
- rsp_tag  out  TAGW  echoed tag
- rsp_sum  out  16  fp16 sum
- busy  out  1  any op in flight or FIFO non-empty

## Operation
- Credit rule:
  - inflight = popcount of the tracker valid bits.
  - Issue is permitted only when fifo_count + inflight < DEPTH.
  - A pop in the same cycle earns no credit (conservative).
- Arbitration:
  - Round-robin over req_valid, starting at index ptr+1 and wrapping.
  - req_ready[i] is high for the winner only, and only when issue is permitted.
  - req_ready depends combinationally on req_valid.
  - Accept = req_valid[i] & req_ready[i].
- On accept, the following load at the same edge:
  - add_a/add_b ← req_a[i]/req_b[i];
  - ptr ← i;
  - tracker stage 0 ← {valid=1, id=i, tag}.
- No accept: add_a/add_b ← 16'h0000 and tracker stage 0 valid ← 0.
- Tracker:
  - Shift register of ADD_LAT+1 stages {valid, id, tag}, advancing every cycle unconditionally.
  - The adder never stalls.
- Capture: when the last tracker stage is valid, push {id, tag, add_sum} into the FIFO.
- Pop: at the edge where rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Push while full is impossible by the credit rule; it is an assertion failure.
- busy = |tracker valids | (fifo_count != 0).

## Timing
- Reset values:
  - req_ready=0, add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_sum=0, busy=0.
  - Tracker cleared, FIFO empty, ptr=NREQ-1 (requester 0 has first priority).
- Latency with an empty FIFO: accept at edge E0 gives rsp_valid high after edge E0+ADD_LAT+1 (4 cycles at default).
- Throughput: one accept per cycle while credit allows; responses leave in issue order.
- Reset mid-operation:
  - All in-flight and buffered results are discarded.
  - No response is produced for pre-reset accepts.
  - The adder shares reset10.
- The FIFO head is stable while rsp_valid & !rsp_ready.
- The FIFO is read/write-pointer based with wrap-around at DEPTH.
- The count ranges 0..DEPTH.

## Structure
- Package fp16_arb_pkg holds:
  - FP16_W=16;
  - default ADD_LAT;
  - typedef rsp_entry_t {id, tag, sum};
  - typedef trk_entry_t {valid, id, tag}.
- Sub-module rr_arbiter: parameter N, inputs req[N], enable, ptr; output one-hot gnt[N]. It is purely combinational; the pointer register stays in the parent.
- The FIFO and tracker are inline in fp16_add_arbiter.
- The adder is instantiated by the parent integration, not inside this block.

## Test plan
- Single op: requester 2 sends 0x3C00 + 0x4000, tag 5 → rsp_valid 4 cycles after accept with rsp_sum 0x4200, rsp_id 2, rsp_tag 5.
- All four requesters valid simultaneously with 0x3E00 + 0x3E00 → grants in order 0,1,2,3 on consecutive cycles, then 4 responses of 0x4200 back-to-back in id order.
- Requesters 0 and 2 continuously valid → grants alternate 0,2,0,2; neither starves.
- rsp_ready held 0 with all requesters streaming → exactly 8 accepts. req_ready stays 0 after that. Raising rsp_ready drains 0x… entries in order and grants resume.
- Reset asserted 2 cycles after an accept → no rsp_valid afterwards. busy=0, add_a=0, and the next grant goes to requester 0.
- Push and pop in the same cycle at fifo_count=DEPTH-1 → count is unchanged and the order is preserved.
